muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle multiply/divide unit in the execute stage, directly downstream of the register file.
//  Consumes ReadData1/ReadData2 (rs/rt) and holds results in internal HI/LO registers.
//  Supports MULT/MULTU/DIV/DIVU (iterative) and MTHI/MTLO (single-cycle).
//  Control reads HI/LO for MFHI/MFLO and stalls the PC while busy=1.
// PARAMETERS
//  WIDTH   32  operand width; HI and LO are each WIDTH bits
//  CNT_W    6  iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      clock; all state changes on posedge
//  rst_n      in   1      synchronous active-low reset
//  start      in   1      request; accepted only on an edge where busy=0
//  Op         in   3      operation code (muldiv_pkg)
//  OperandA   in   WIDTH  rs value (ReadData1): multiplicand / dividend / MTHI-MTLO source
//  OperandB   in   WIDTH  rt value (ReadData2): multiplier / divisor
//  busy       out  1      high while an iterative operation is in flight
//  done       out  1      one-cycle pulse: HI/LO just updated by an iterative op
//  HI         out  WIDTH  HI register
//  LO         out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE, counter=0; HI, LO, busy, done all 0. Aborts any op in flight; nothing partial is written.
//  - FSM states: IDLE -> CALC -> FIX -> IDLE.
//  - IDLE, start=1, op MULT/MULTU/DIV/DIVU: latch |A|, |B| (signed ops) or A, B (unsigned).
//    Latch result signs; clear accumulator; go to CALC with counter=0.
//  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per edge.
//    After WIDTH steps, go to FIX.
//  - FIX: apply sign correction, write HI/LO at that edge, set done=1 for the next cycle, return to IDLE.
//  - Latency: accept at edge E0; HI/LO valid and done=1 after edge E0+WIDTH+1 (33 for WIDTH=32).
//    busy=1 in the cycles after E0 through E0+WIDTH.
//  - Back-to-back: start may be accepted in the cycle where done=1.
//  - MTHI/MTLO (IDLE, start=1): HI (resp. LO) <= OperandA at that edge. busy stays 0, done is not pulsed.
//  - start while busy=1: ignored. Op and operands are not re-sampled. Control must hold the instruction until busy=0.
//  - Multiply: {HI,LO} = A*B as a 2*WIDTH-bit product. Signed result is negated iff sign(A) != sign(B).
//  - Divide: LO = quotient, HI = remainder.
//    Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
//  - Signed overflow: DIV of 0x80000000 by 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  - Divide by zero (any DIV/DIVU with B=0): runs full latency.
//    Result LO=all ones, HI=OperandA as latched (raw A, no sign fix). No trap.
//  - Undefined Op codes with start=1: no effect, stay IDLE.
//  - HI/LO are never modified except at FIX, by MTHI/MTLO, or by reset.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined: MULT/MULTU complete combinationally at acceptance.
//    {HI,LO} is written at E0, done=1 after E0, busy stays 0. DIV/DIVU are unchanged (iterative).
//  Not defined: every multiply uses the WIDTH+1-cycle iterative path described above.
// STRUCTURE
//  muldiv_pkg:
//    localparams OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5.
//    State encodings S_IDLE, S_CALC, S_FIX.
//  Sub-module muldiv_step: combinational single-iteration datapath. Inputs: mode, acc, operand.
//    Outputs: next acc/quotient bits.
//  muldiv_unit keeps the FSM, counter, sign latches and HI/LO.
// TESTING
//  1 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001; done pulses once.
//  2 MULT A=-7 (0xFFFFFFF9) B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
//    busy=1 for exactly 33 cycles.
//  3 DIV A=-7 B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
//    DIVU A=7 B=2 -> LO=3, HI=1.
//  4 DIVU A=0x1234 B=0 -> LO=0xFFFFFFFF, HI=0x1234.
//    DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  5 MTHI A=0xDEADBEEF -> HI=0xDEADBEEF next cycle, busy=0, no done.
//    Then start pulses with new operands during an in-flight MULT -> ignored; result matches the first operands.
//  6 rst_n=0 at cycle 10 of a DIV -> next cycle busy=0, done=0, HI=LO=0.
//    A new MULTU 3*5 then gives LO=15, HI=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and opcode-decode helpers for the
// multiply/divide unit.
package muldiv_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_e;

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between control and the multiply/divide unit.
// start is a request qualified by !busy: it is taken on any edge where the unit is idle and ignored while busy=1,
// so control holds start/Op/operands until busy=0; done is a one-cycle pulse after HI/LO are written.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = 32);
    logic              start;
    logic [OP_W-1:0]   Op;
    logic [WIDTH-1:0]  OperandA;
    logic [WIDTH-1:0]  OperandB;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  HI;
    logic [WIDTH-1:0]  LO;
    state_e            dbg_state;

    modport master (
        output start, Op, OperandA, OperandB,
        input  busy, done, HI, LO, dbg_state
    );

    modport slave (
        input  start, Op, OperandA, OperandB,
        output busy, done, HI, LO, dbg_state
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply on {acc,mq},
// or restoring shift-subtract divide with the quotient shifting into mq.
module muldiv_step import muldiv_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  mode_e             mode,
    input  logic [WIDTH-1:0]  acc,
    input  logic [WIDTH-1:0]  mq,
    input  logic [WIDTH-1:0]  operand,
    output logic [WIDTH-1:0]  acc_next,
    output logic [WIDTH-1:0]  mq_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        sum      = {1'b0, acc} + (mq[0] ? {1'b0, operand} : '0);
        shifted  = {acc, mq[WIDTH-1]};
        ge       = (shifted >= {1'b0, operand});
        acc_next = '0;
        mq_next  = '0;
        if (mode == MODE_MUL) begin
            acc_next = sum[WIDTH:1];
            mq_next  = {sum[0], mq[WIDTH-1:1]};
        end else begin
            // Partial remainder stays below the divisor, so it fits in WIDTH bits.
            acc_next = ge ? (shifted[WIDTH-1:0] - operand) : shifted[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], ge};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO (IDLE -> CALC -> FIX -> IDLE).
// Optional MULDIV_FAST_MUL_EN: MULT/MULTU complete combinationally at acceptance.
module muldiv_unit import muldiv_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    muldiv_if.slave    bus
);
    state_e              state, state_next;
    mode_e               mode;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    acc, mq, opnd, a_raw, hi, lo;
    logic                neg_q, neg_r, div_zero, done_q;
    logic                accept, last_step, iter_req;
    logic                sign_a, sign_b;
    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [WIDTH-1:0]    acc_step, mq_step;
    logic [2*WIDTH-1:0]  prod_fix;
    logic [WIDTH-1:0]    q_fix, r_fix;

    assign sign_a = is_signed_op(bus.Op) & bus.OperandA[WIDTH-1];
    assign sign_b = is_signed_op(bus.Op) & bus.OperandB[WIDTH-1];
    assign abs_a  = sign_a ? -bus.OperandA : bus.OperandA;
    assign abs_b  = sign_b ? -bus.OperandB : bus.OperandB;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_mag, fast_prod;
    assign iter_req  = is_div_op(bus.Op);
    assign fast_mag  = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
    assign fast_prod = (sign_a ^ sign_b) ? -fast_mag : fast_mag;
`else
    assign iter_req  = is_mul_op(bus.Op) | is_div_op(bus.Op);
`endif

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .mq       (mq),
        .operand  (opnd),
        .acc_next (acc_step),
        .mq_next  (mq_step)
    );

    // Sign fix-up applied at FIX; remainder follows the dividend's sign.
    assign prod_fix = neg_q ? -{acc, mq} : {acc, mq};
    assign q_fix    = neg_q ? -mq : mq;
    assign r_fix    = neg_r ? -acc : acc;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                accept = bus.start;
                if (bus.start && iter_req) state_next = S_CALC;
            end
            S_CALC:  if (last_step) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mode     <= MODE_MUL;
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && iter_req) begin
                        mode     <= is_div_op(bus.Op) ? MODE_DIV : MODE_MUL;
                        cnt      <= '0;
                        acc      <= '0;
                        mq       <= is_div_op(bus.Op) ? abs_a : abs_b;
                        opnd     <= is_div_op(bus.Op) ? abs_b : abs_a;
                        a_raw    <= bus.OperandA;
                        neg_q    <= sign_a ^ sign_b;
                        neg_r    <= sign_a;
                        div_zero <= is_div_op(bus.Op) && (bus.OperandB == '0);
                    end else if (accept && bus.Op == OP_MTHI) begin
                        hi <= bus.OperandA;
                    end else if (accept && bus.Op == OP_MTLO) begin
                        lo <= bus.OperandA;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (accept && is_mul_op(bus.Op)) begin
                        {hi, lo} <= fast_prod;
                        done_q   <= 1'b1;
`endif
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    mq  <= mq_step;
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (mode == MODE_MUL) begin
                        {hi, lo} <= prod_fix;
                    end else if (div_zero) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done_q;
    assign bus.HI        = hi;
    assign bus.LO        = lo;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a
// behavioural model, and hand sequences for MTHI/MTLO, ignored starts and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_if #(.WIDTH(W)) bus();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            OP_DIV:   if (b == '0) r = {a, {W{1'b1}}};
                      else begin
                          r[31:0]  = 32'(sa / sb);
                          r[63:32] = 32'(sa % sb);
                      end
            OP_DIVU:  if (b == '0) r = {a, {W{1'b1}}};
                      else r = {a % b, a / b};
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        return (FAST_MUL && is_mul_op(op)) ? 0 : W + 1;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [63:0] exp);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.Op       = op;
        bus.OperandA = a;
        bus.OperandB = b;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (!(FAST_MUL && is_mul_op(op))) check("done_low_at_accept", 64'(bus.done), 64'(0));
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int cyc      = 0;
        int busy_cnt = 0;
        bit hold_ok  = 1'b1;
        logic [63:0] exp;
        if (bus.busy) busy_cnt++;
        while (!bus.done && cyc < 200) begin
            if (bus.HI !== m_hi || bus.LO !== m_lo) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.busy) busy_cnt++;
        end
        check({name, " done"}, 64'(bus.done), 64'(1));
        if (exp_lat >= 0) begin
            check({name, " latency"}, 64'(cyc), 64'(exp_lat));
            check({name, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        end
        check({name, " hilo_held"}, 64'(hold_ok), 64'(1));
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check({name, " hi_lo"}, {bus.HI, bus.LO}, exp);
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic [2:0]   in_op;
        bit           done_seen;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{OP_MULTU, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[10] = '{OP_DIVU,  32'h00000005, 32'h00000009, 32'h00000005, 32'h00000000};
        vecs[11] = '{OP_MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};

        // Clock/reset
        bus.start    = 1'b0;
        bus.Op       = OP_MULT;
        bus.OperandA = '0;
        bus.OperandB = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset hi_lo", {bus.HI, bus.LO}, 64'(0));
        check("reset state", 64'(bus.dbg_state), 64'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, issued back to back (each start lands in the done cycle)
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
            wait_result($sformatf("vec%0d", i), lat_of(vecs[i].op));
        end

        // Random operations against the behavioural model
        for (int i = 0; i < 8; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
            issue(op, a, b, ref_result(op, a, b));
            wait_result($sformatf("rand%0d", i), lat_of(op));
        end

        // MTHI / MTLO: single-cycle, no busy, no done
        @(negedge clk);
        bus.start = 1'b1; bus.Op = OP_MTHI; bus.OperandA = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mthi hi", 64'(bus.HI), 64'(32'hDEADBEEF));
        check("mthi lo", 64'(bus.LO), 64'(m_lo));
        check("mthi busy", 64'(bus.busy), 64'(0));
        check("mthi done", 64'(bus.done), 64'(0));
        m_hi = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b1; bus.Op = OP_MTLO; bus.OperandA = 32'h13579BDF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("mtlo hi_lo", {bus.HI, bus.LO}, {m_hi, 32'h13579BDF});
        check("mtlo done", 64'(bus.done), 64'(0));
        m_lo = 32'h13579BDF;

        // Undefined opcodes: no effect
        for (int k = 6; k < 8; k++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.Op = 3'(k); bus.OperandA = 32'h0BADF00D;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            check($sformatf("undef%0d busy", k), 64'(bus.busy), 64'(0));
            check($sformatf("undef%0d hi_lo", k), {bus.HI, bus.LO}, {m_hi, m_lo});
            @(posedge clk);
            #1;
            check($sformatf("undef%0d done", k), 64'(bus.done), 64'(0));
        end

        // Starts while busy are ignored, operands are not re-sampled
        in_op = FAST_MUL ? OP_DIV : OP_MULT;
        issue(in_op, 32'd100, 32'hFFFFFFFD, ref_result(in_op, 32'd100, 32'hFFFFFFFD));
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.Op = OP_MTLO; bus.OperandA = 32'h55555555;
        @(negedge clk);
        bus.Op = OP_MULTU; bus.OperandA = 32'h00000009; bus.OperandB = 32'h00000009;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_result("ignored_start", -1);

        // Reset ten cycles into a DIV aborts it without touching HI/LO afterwards
        issue(OP_DIV, 32'd1000, 32'd7, ref_result(OP_DIV, 32'd1000, 32'd7));
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 64'(bus.busy), 64'(0));
        check("abort done", 64'(bus.done), 64'(0));
        check("abort hi_lo", {bus.HI, bus.LO}, 64'(0));
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_seen = 1'b1;
        end
        check("abort no_late_done", 64'(done_seen), 64'(0));
        check("abort hi_lo_kept", {bus.HI, bus.LO}, 64'(0));
        issue(OP_MULTU, 32'd3, 32'd5, {32'd0, 32'd15});
        wait_result("post_reset_multu", lat_of(OP_MULTU));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
